// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit feeding the register file write port.
// Optional MULDIV_EARLY_OUT_EN: trivial operands bypass the 32-cycle iteration.
module mul_div_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk_MulDiv,
   input  logic            rst,
   input  logic            Start,
   input  logic [2:0]      Funct3,
   input  logic [XLEN-1:0] Src_A,
   input  logic [XLEN-1:0] Src_B,
   input  logic [4:0]      Rd_Addr,
   output logic            Busy,
   output logic            Done,
   output logic            Reg_Write,
   output logic [4:0]      W_Addr,
   output logic [XLEN-1:0] W_Data
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_busy;
   logic                r_done;
   logic                r_reg_write;
   logic [4:0]          r_w_addr;
   logic [XLEN-1:0]     r_w_data;

   logic [2:0]          r_funct3;
   logic [4:0]          r_rd;
   logic [XLEN-1:0]     r_src_a;
   logic [XLEN-1:0]     r_a_mag;
   logic [XLEN-1:0]     r_b_mag;
   logic                r_neg_res;
   logic                r_neg_rem;
   logic                r_b_zero;
   logic [2*XLEN-1:0]   r_prod;
   logic [XLEN-1:0]     r_quo;
   logic [XLEN-1:0]     r_rem;

   logic                w_is_div;
   logic                w_a_sgn;
   logic                w_b_sgn;
   logic                w_a_neg;
   logic                w_b_neg;
   logic [XLEN-1:0]     w_a_mag;
   logic [XLEN-1:0]     w_b_mag;
   logic                w_early;
   logic [XLEN:0]       w_mul_sum;
   logic [XLEN:0]       w_div_sh;
   logic                w_div_ge;
   logic [XLEN-1:0]     w_div_diff;
   logic [2*XLEN-1:0]   w_prod_fix;
   logic [XLEN-1:0]     w_quo_fix;
   logic [XLEN-1:0]     w_rem_fix;
   logic [XLEN-1:0]     w_result;

   function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] x, input logic n);
      return n ? -x : x;
   endfunction

   function automatic logic [2*XLEN-1:0] neg_if_w(input logic [2*XLEN-1:0] x, input logic n);
      return n ? -x : x;
   endfunction

   // Operand signedness: MUL/MULH signed x signed, MULHSU signed x unsigned, DIV/REM signed
   assign w_is_div = Funct3[2];
   assign w_a_sgn  = w_is_div ? ~Funct3[0] : (Funct3[1:0] != 2'b11);
   assign w_b_sgn  = w_is_div ? ~Funct3[0] : ~Funct3[1];
   assign w_a_neg  = w_a_sgn & Src_A[XLEN-1];
   assign w_b_neg  = w_b_sgn & Src_B[XLEN-1];
   assign w_a_mag  = neg_if(Src_A, w_a_neg);
   assign w_b_mag  = neg_if(Src_B, w_b_neg);

`ifdef MULDIV_EARLY_OUT_EN
   logic w_ovf;
   assign w_ovf   = w_is_div & ~Funct3[0] & (Src_A == {1'b1, {(XLEN-1){1'b0}}}) & (&Src_B);
   assign w_early = (Src_A == '0) | (Src_B == '0) | w_ovf;
`else
   assign w_early = 1'b0;
`endif

   assign w_mul_sum  = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, (r_prod[0] ? r_a_mag : '0)};
   assign w_div_sh   = {r_rem, r_quo[XLEN-1]};
   assign w_div_ge   = (w_div_sh >= {1'b0, r_b_mag});
   assign w_div_diff = w_div_sh[XLEN-1:0] - r_b_mag;

   assign w_prod_fix = neg_if_w(r_prod, r_neg_res);
   assign w_quo_fix  = neg_if(r_quo, r_neg_res);
   assign w_rem_fix  = neg_if(r_rem, r_neg_rem);

   always_comb begin
      w_result = '0;
      case (r_funct3)
         3'b000:                 w_result = w_prod_fix[XLEN-1:0];
         3'b001, 3'b010, 3'b011: w_result = w_prod_fix[2*XLEN-1:XLEN];
         3'b100, 3'b101:         w_result = r_b_zero ? '1 : w_quo_fix;
         default:                w_result = r_b_zero ? r_src_a : w_rem_fix;
      endcase
   end

   // Datapath registers: loaded at acceptance, stepped once per CALC cycle
   always_ff @(posedge clk_MulDiv) begin
      if (r_state == S_IDLE && Start) begin
         r_funct3  <= Funct3;
         r_rd      <= Rd_Addr;
         r_src_a   <= Src_A;
         r_a_mag   <= w_a_mag;
         r_b_mag   <= w_b_mag;
         r_neg_res <= w_a_neg ^ w_b_neg;
         r_neg_rem <= w_a_neg;
         r_b_zero  <= (Src_B == '0);
         r_prod    <= {{XLEN{1'b0}}, w_b_mag};
         r_quo     <= w_a_mag;
         r_rem     <= '0;
`ifdef MULDIV_EARLY_OUT_EN
         if (w_early) begin
            r_prod <= '0;
            r_quo  <= w_ovf ? {1'b1, {(XLEN-1){1'b0}}} : '0;
         end
`endif
      end else if (r_state == S_CALC) begin
         if (r_funct3[2]) begin
            r_quo <= {r_quo[XLEN-2:0], w_div_ge};
            r_rem <= w_div_ge ? w_div_diff : w_div_sh[XLEN-1:0];
         end else begin
            r_prod <= {w_mul_sum, r_prod[XLEN-1:1]};
         end
      end
   end

   // Control FSM and registered write-port outputs
   always_ff @(posedge clk_MulDiv) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_reg_write <= 1'b0;
         r_w_addr    <= '0;
         r_w_data    <= '0;
      end else begin
         r_done      <= 1'b0;
         r_reg_write <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (Start) begin
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= w_early ? S_FIX : S_CALC;
               end
            end
            S_CALC: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(XLEN-1)) r_state <= S_FIX;
            end
            S_FIX: begin
               r_w_data    <= w_result;
               r_w_addr    <= r_rd;
               r_done      <= 1'b1;
               r_reg_write <= (r_rd != 5'd0);
               r_state     <= S_DONE;
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign Busy      = r_busy;
   assign Done      = r_done;
   assign Reg_Write = r_reg_write;
   assign W_Addr    = r_w_addr;
   assign W_Data    = r_w_data;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed RV32M vectors, latency and write-port checks.
module tb_mul_div_unit;

   logic        clk;
   logic        rst;
   logic        Start;
   logic [2:0]  Funct3;
   logic [31:0] Src_A;
   logic [31:0] Src_B;
   logic [4:0]  Rd_Addr;
   logic        Busy;
   logic        Done;
   logic        Reg_Write;
   logic [4:0]  W_Addr;
   logic [31:0] W_Data;

   mul_div_unit #(.XLEN(32), .CNT_W(6)) dut (
      .clk_MulDiv (clk),
      .rst        (rst),
      .Start      (Start),
      .Funct3     (Funct3),
      .Src_A      (Src_A),
      .Src_B      (Src_B),
      .Rd_Addr    (Rd_Addr),
      .Busy       (Busy),
      .Done       (Done),
      .Reg_Write  (Reg_Write),
      .W_Addr     (W_Addr),
      .W_Data     (W_Data)
   );

   typedef struct {
      logic [31:0] data;
      logic [4:0]  addr;
      logic        wr;
      int          done_cyc;
      string       name;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   function automatic int lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      int  l;
      logic e;
      l = 34;
      e = (a == 32'd0) || (b == 32'd0) ||
          (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef MULDIV_EARLY_OUT_EN
      if (e) l = 2;
`else
      if (e) l = 34;
`endif
      return l;
   endfunction

   // Monitor: every Done pops one expectation; writes without Done are errors
   always @(negedge clk) begin
      if (Done) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=Done=1 required=no_pending_op (cycle %0d)", cyc);
         end else begin
            mon_e = sb.pop_front();
            chk({mon_e.name, "_data"}, W_Data, mon_e.data);
            chk({mon_e.name, "_addr"}, {27'd0, W_Addr}, {27'd0, mon_e.addr});
            chk({mon_e.name, "_wr"}, {31'd0, Reg_Write}, {31'd0, mon_e.wr});
            chk({mon_e.name, "_cycle"}, cyc, mon_e.done_cyc);
         end
      end else if (Reg_Write) begin
         checks++;
         failures++;
         $display("FAIL stray_write actual=Reg_Write=1 required=0 (cycle %0d)", cyc);
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (Busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (Busy) begin
         checks++;
         failures++;
         $display("FAIL busy_timeout actual=Busy=1 required=0 (cycle %0d)", cyc);
      end
   endtask

   task automatic push_exp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input logic [31:0] res, input string nm,
                           input int acc);
      exp_t e;
      e.data     = res;
      e.addr     = rd;
      e.wr       = (rd != 5'd0);
      e.done_cyc = acc + lat(f, a, b);
      e.name     = nm;
      sb.push_back(e);
   endtask

   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] res, input string nm,
                        output int acc);
      wait_idle();
      Start   = 1'b1;
      Funct3  = f;
      Src_A   = a;
      Src_B   = b;
      Rd_Addr = rd;
      acc     = cyc;
      push_exp(f, a, b, rd, res, nm, acc);
      @(negedge clk);
      Start   = 1'b0;
      Funct3  = 3'($urandom);
      Src_A   = $urandom;
      Src_B   = $urandom;
      Rd_Addr = 5'($urandom);
   endtask

   task automatic wait_cyc(input int target);
      int n;
      n = 0;
      while (cyc < target && n < 500) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      int acc;
      int n;
      rst     = 1'b1;
      Start   = 1'b0;
      Funct3  = 3'd0;
      Src_A   = 32'd0;
      Src_B   = 32'd0;
      Rd_Addr = 5'd0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, Busy}, 32'd0);
      chk("rst_done", {31'd0, Done}, 32'd0);
      chk("rst_wr", {31'd0, Reg_Write}, 32'd0);
      chk("rst_waddr", {27'd0, W_Addr}, 32'd0);
      chk("rst_wdata", W_Data, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, "mul", acc);
      wait_cyc(acc + 34);
      chk("mul_busy_c34", {31'd0, Busy}, 32'd1);
      @(negedge clk);
      chk("mul_busy_c35", {31'd0, Busy}, 32'd0);

      issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, "mulh", acc);
      issue(3'b010, 32'h8000_0000, 32'h8000_0000, 5'd7,  32'hC000_0000, "mulhsu", acc);
      issue(3'b011, 32'h8000_0000, 32'h8000_0000, 5'd8,  32'h4000_0000, "mulhu", acc);
      issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd21, 32'hFFFF_FFFE, "mulhu_max", acc);
      issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'h0000_0001, "mul_m1", acc);
      issue(3'b100, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, "div_n7_2", acc);
      issue(3'b110, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, "rem_n7_2", acc);
      issue(3'b101, 32'hFFFF_FFFF, 32'd16,        5'd11, 32'h0FFF_FFFF, "divu", acc);
      issue(3'b111, 32'd100,       32'd7,         5'd15, 32'd2,         "remu", acc);
      issue(3'b100, 32'd20,        32'hFFFF_FFFD, 5'd19, 32'hFFFF_FFFA, "div_20_n3", acc);
      issue(3'b110, 32'd20,        32'hFFFF_FFFD, 5'd20, 32'd2,         "rem_20_n3", acc);
      issue(3'b100, 32'h1234_5678, 32'd0,         5'd12, 32'hFFFF_FFFF, "div_by0", acc);
      issue(3'b110, 32'h1234_5678, 32'd0,         5'd13, 32'h1234_5678, "rem_by0", acc);
      issue(3'b101, 32'h1234_5678, 32'd0,         5'd14, 32'hFFFF_FFFF, "divu_by0", acc);
      issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, "div_ovf", acc);
      issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0,         "rem_ovf", acc);
      issue(3'b000, 32'd0,         32'd5,         5'd18, 32'd0,         "mul_zero", acc);
      issue(3'b000, 32'd3,         32'd4,         5'd0,  32'd12,        "mul_rd0", acc);

      // Start held high through a whole op: second op accepted only in cycle 35
      wait_idle();
      Start   = 1'b1;
      Funct3  = 3'b011;
      Src_A   = 32'hFFFF_FFFF;
      Src_B   = 32'd2;
      Rd_Addr = 5'd22;
      acc     = cyc;
      push_exp(3'b011, 32'hFFFF_FFFF, 32'd2, 5'd22, 32'd1, "held_first", acc);
      @(negedge clk);
      Funct3  = 3'b000;
      Src_A   = 32'd6;
      Src_B   = 32'd7;
      Rd_Addr = 5'd23;
      wait_cyc(acc + 35);
      chk("held_busy_c35", {31'd0, Busy}, 32'd0);
      push_exp(3'b000, 32'd6, 32'd7, 5'd23, 32'd42, "held_second", cyc);
      @(negedge clk);
      Start = 1'b0;

      // Reset in cycle 10 of a DIV discards it
      wait_idle();
      Start   = 1'b1;
      Funct3  = 3'b100;
      Src_A   = 32'd100;
      Src_B   = 32'd7;
      Rd_Addr = 5'd24;
      acc     = cyc;
      @(negedge clk);
      Start = 1'b0;
      wait_cyc(acc + 10);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", {31'd0, Busy}, 32'd0);
      chk("abort_done", {31'd0, Done}, 32'd0);
      chk("abort_wdata", W_Data, 32'd0);
      chk("abort_waddr", {27'd0, W_Addr}, 32'd0);
      repeat (40) @(negedge clk);
      issue(3'b100, 32'd100, 32'd7, 5'd24, 32'd14, "div_after_rst", acc);

      n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout actual=%0d_pending required=0", sb.size());
      end
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
